// File: rtl/demux_10bit_buffered_pkg.sv
// Shared constants for the buffered 10-bit result demultiplexer.
//   DATA_W : result word width
//   DEPTH  : default entries per destination FIFO
//   CNT_W  : default occupancy width, log2(DEPTH)+1
//   dest_e : destination encoding (A=0, B=1)
package demux_10bit_buffered_pkg;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } dest_e;

endpackage

// File: rtl/demux_fifo.sv
// Single-channel synchronous FIFO used once per demux destination.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (clears storage)
//   push, wdata   : write request and word (ignored when full)
//   pop           : read request (ignored when empty)
//   rdata, valid  : head entry and not-empty flag
//   full, count   : occupancy status
module demux_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Status and head word come straight from registered state
  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/demux_10bit_buffered.sv
// Steers a 10-bit SAR result stream to one of two buffered destinations.
// Destination is in_select (mode_alt=0) or an internal ping-pong pointer
// (mode_alt=1) that advances on each accepted word.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   in_data, in_valid, in_ready      : source handshake (in_ready combinational)
//   in_select, mode_alt              : steering control
//   out_a_data/valid/ready, a_count  : destination A FIFO
//   out_b_data/valid/ready, b_count  : destination B FIFO
module demux_10bit_buffered #(
  parameter int unsigned DATA_W = demux_10bit_buffered_pkg::DATA_W,
  parameter int unsigned DEPTH  = demux_10bit_buffered_pkg::DEPTH,
  parameter int unsigned CNT_W  = demux_10bit_buffered_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_select,
  input  logic              mode_alt,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_a_data,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [DATA_W-1:0] out_b_data,
  output logic              out_b_valid,
  input  logic              out_b_ready,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  import demux_10bit_buffered_pkg::*;

  logic alt_ptr;
  logic dest;
  logic full_a;
  logic full_b;
  logic accept;
  logic push_a;
  logic push_b;

  // A blocked word is never redirected: ready tracks only the chosen FIFO
  assign dest     = mode_alt ? alt_ptr : in_select;
  assign in_ready = (dest == DEST_B) ? ~full_b : ~full_a;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & (dest == DEST_A);
  assign push_b   = accept & (dest == DEST_B);

  // Ping-pong pointer holds while mode_alt=0 so ping-pong resumes where it left off
  always_ff @(posedge clk) begin
    if (rst) begin
      alt_ptr <= DEST_A;
    end else if (accept && mode_alt) begin
      alt_ptr <= ~alt_ptr;
    end
  end

  demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .wdata (in_data),
    .pop   (out_a_ready),
    .rdata (out_a_data),
    .valid (out_a_valid),
    .full  (full_a),
    .count (a_count)
  );

  demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .wdata (in_data),
    .pop   (out_b_ready),
    .rdata (out_b_data),
    .valid (out_b_valid),
    .full  (full_b),
    .count (b_count)
  );

endmodule

// File: tb/tb_demux_10bit_buffered.sv
// Directed, table-driven bench for demux_10bit_buffered.
module tb_demux_10bit_buffered;

  import demux_10bit_buffered_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_select;
  logic              mode_alt;
  logic              in_ready;
  logic [DATA_W-1:0] out_a_data;
  logic              out_a_valid;
  logic              out_a_ready;
  logic [DATA_W-1:0] out_b_data;
  logic              out_b_valid;
  logic              out_b_ready;
  logic [CNT_W-1:0]  a_count;
  logic [CNT_W-1:0]  b_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_10bit_buffered dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_select   (in_select),
    .mode_alt    (mode_alt),
    .in_ready    (in_ready),
    .out_a_data  (out_a_data),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b_data  (out_b_data),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .a_count     (a_count),
    .b_count     (b_count)
  );

  typedef struct {
    logic             rst;
    logic             vld;
    logic             sel;
    logic             alt;
    logic [9:0]       data;
    logic             ar;
    logic             br;
    logic             chk_rdy;  // in_ready checked before the edge
    logic             rdy;
    logic             av;       // expected state after the edge
    logic [9:0]       ad;
    logic [1:0]       ac;
    logic             bv;
    logic [9:0]       bd;
    logic [1:0]       bc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic vld, input logic sel, input logic alt,
                     input logic [9:0] data, input logic ar, input logic br,
                     input logic chk_rdy, input logic rdy,
                     input logic av, input logic [9:0] ad, input logic [1:0] ac,
                     input logic bv, input logic [9:0] bd, input logic [1:0] bc);
    vec_t v;
    v.rst = r; v.vld = vld; v.sel = sel; v.alt = alt; v.data = data;
    v.ar = ar; v.br = br; v.chk_rdy = chk_rdy; v.rdy = rdy;
    v.av = av; v.ad = ad; v.ac = ac; v.bv = bv; v.bd = bd; v.bc = bc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; in_valid = v.vld; in_select = v.sel; mode_alt = v.alt;
    in_data = v.data; out_a_ready = v.ar; out_b_ready = v.br;
    #1;
    if (v.chk_rdy) check("in_ready", idx, 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    check("out_a_valid", idx, 32'(out_a_valid), 32'(v.av));
    check("a_count",     idx, 32'(a_count),     32'(v.ac));
    check("out_b_valid", idx, 32'(out_b_valid), 32'(v.bv));
    check("b_count",     idx, 32'(b_count),     32'(v.bc));
    if (v.av) check("out_a_data", idx, 32'(out_a_data), 32'(v.ad));
    if (v.bv) check("out_b_data", idx, 32'(out_b_data), 32'(v.bd));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_select = 1'b0; mode_alt = 1'b0;
    in_data = '0; out_a_ready = 1'b0; out_b_ready = 1'b0;

    //   rst vld sel alt data    ar br chk rdy   av ad      ac  bv bd      bc
    // Reset, then idle with either select
    add(1, 0, 0, 0, 10'h000, 0, 0, 0, 0,   0, 10'h000, 0,  0, 10'h000, 0);
    add(0, 0, 0, 0, 10'h000, 0, 0, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    add(0, 0, 1, 0, 10'h000, 0, 0, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    // Explicit select A, latency 1, then drain
    add(0, 1, 0, 0, 10'h2A5, 0, 0, 1, 1,   1, 10'h2A5, 1,  0, 10'h000, 0);
    add(0, 0, 0, 0, 10'h000, 1, 0, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    // Fill B, third word blocked, no pass-through on pop
    add(0, 1, 1, 0, 10'h001, 0, 0, 1, 1,   0, 10'h000, 0,  1, 10'h001, 1);
    add(0, 1, 1, 0, 10'h3FF, 0, 0, 1, 1,   0, 10'h000, 0,  1, 10'h001, 2);
    add(0, 1, 1, 0, 10'h155, 0, 0, 1, 0,   0, 10'h000, 0,  1, 10'h001, 2);
    add(0, 1, 1, 0, 10'h155, 0, 1, 1, 0,   0, 10'h000, 0,  1, 10'h3FF, 1);
    add(0, 1, 1, 0, 10'h155, 0, 1, 1, 1,   0, 10'h000, 0,  1, 10'h155, 1);
    add(0, 0, 1, 0, 10'h000, 0, 1, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    // Same-cycle push and pop on A holding one word
    add(0, 1, 0, 0, 10'h0AA, 0, 0, 1, 1,   1, 10'h0AA, 1,  0, 10'h000, 0);
    add(0, 1, 0, 0, 10'h0BB, 1, 0, 1, 1,   1, 10'h0BB, 1,  0, 10'h000, 0);
    add(0, 0, 0, 0, 10'h000, 1, 0, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    // Ping-pong back-to-back, both readies high (in_select ignored)
    add(0, 1, 1, 1, 10'h010, 1, 1, 1, 1,   1, 10'h010, 1,  0, 10'h000, 0);
    add(0, 1, 0, 1, 10'h020, 1, 1, 1, 1,   0, 10'h000, 0,  1, 10'h020, 1);
    add(0, 1, 1, 1, 10'h030, 1, 1, 1, 1,   1, 10'h030, 1,  0, 10'h000, 0);
    add(0, 1, 0, 1, 10'h040, 1, 1, 1, 1,   0, 10'h000, 0,  1, 10'h040, 1);
    // Gap of three idle cycles, pops on empty ignored
    add(0, 0, 0, 1, 10'h000, 1, 1, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    add(0, 0, 1, 1, 10'h000, 1, 1, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    add(0, 0, 0, 1, 10'h000, 1, 1, 1, 1,   0, 10'h000, 0,  0, 10'h000, 0);
    // Explicit push to B holds pointer at A; ping-pong resumes at A
    add(0, 1, 1, 0, 10'h111, 0, 0, 1, 1,   0, 10'h000, 0,  1, 10'h111, 1);
    add(0, 1, 1, 1, 10'h222, 0, 0, 1, 1,   1, 10'h222, 1,  1, 10'h111, 1);
    add(0, 1, 0, 1, 10'h333, 0, 0, 1, 1,   1, 10'h222, 1,  1, 10'h111, 2);
    add(0, 1, 0, 1, 10'h044, 0, 0, 1, 1,   1, 10'h222, 2,  1, 10'h111, 2);
    // Both full: blocked in either mode
    add(0, 1, 0, 1, 10'h055, 0, 0, 1, 0,   1, 10'h222, 2,  1, 10'h111, 2);
    add(0, 1, 0, 0, 10'h055, 0, 0, 1, 0,   1, 10'h222, 2,  1, 10'h111, 2);
    // Reset with both full and a live transfer; pointer was B, restarts at A
    add(1, 1, 0, 1, 10'h066, 1, 1, 0, 0,   0, 10'h000, 0,  0, 10'h000, 0);
    add(0, 1, 1, 1, 10'h077, 0, 0, 1, 1,   1, 10'h077, 1,  0, 10'h000, 0);
    add(0, 1, 0, 1, 10'h088, 0, 0, 1, 1,   1, 10'h077, 1,  1, 10'h088, 1);

    foreach (vecs[i]) apply(vecs[i], i);

    // Head stays stable while A is stalled with no push
    @(negedge clk);
    in_valid = 1'b0; out_a_ready = 1'b0; out_b_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("a_hold_data", 100 + c, 32'(out_a_data), 32'h077);
      check("a_hold_valid", 100 + c, 32'(out_a_valid), 32'h1);
    end

    // Drain B with a bounded wait; exactly one word expected
    begin
      int n;
      n = 0;
      @(negedge clk);
      out_b_ready = 1'b1;
      while (out_b_valid && n < 8) begin
        check("b_drain_data", 200 + n, 32'(out_b_data), 32'h088);
        @(posedge clk); #1;
        n++;
      end
      check("b_drain_count", 300, 32'(n), 32'd1);
      check("b_drain_empty", 301, 32'(b_count), 32'd0);
      out_b_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_10bit_buffered.md
Name: demux_10bit_buffered

Overview:
- Other direction of the 10-bit 2:1 result multiplexer: takes one 10-bit SAR conversion result stream and steers each word to one of two destinations, A or B.
- Each destination has its own small FIFO, so a stalled consumer does not lose words that were already accepted.
- Steering is either explicit (per-word select) or automatic ping-pong.
- Sits between the SAR result register and the two downstream consumers (e.g. wishbone readback and the serial output path).

Parameters:
- DATA_W, 10, word width.
- DEPTH, 2, entries per destination FIFO; power of two, minimum 2.
- CNT_W, 2, width of each occupancy output; equals log2(DEPTH)+1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_data, input, DATA_W, result word.
- in_valid, input, 1, in_data is valid.
- in_select, input, 1, destination when mode_alt=0: 0 selects A, 1 selects B.
- mode_alt, input, 1, 1 selects ping-pong steering and ignores in_select.
- in_ready, output, 1, transfer is accepted this cycle.
- out_a_data, output, DATA_W, head word of the A FIFO.
- out_a_valid, output, 1, A FIFO is not empty.
- out_a_ready, input, 1, A consumer pops.
- out_b_data, output, DATA_W, head word of the B FIFO.
- out_b_valid, output, 1, B FIFO is not empty.
- out_b_ready, input, 1, B consumer pops.
- a_count, output, CNT_W, A FIFO occupancy.
- b_count, output, CNT_W, B FIFO occupancy.

Behaviour:
- Reset (clk edge while rst=1):
  - both FIFOs emptied and storage cleared to 0;
  - out_*_valid=0, out_*_data=0, a_count=b_count=0;
  - ping-pong pointer set to A.
  - Reset takes priority over any transfer in the same cycle, including mid-stream; words held in the FIFOs are discarded.
- Destination: dest = mode_alt ? alt_ptr : in_select (0=A, 1=B).
- in_ready:
  - combinational; equals NOT full of the FIFO chosen by dest;
  - independent of in_valid;
  - no pass-through when full: a same-cycle pop does not raise in_ready.
- Push: when in_valid & in_ready, in_data is written into the dest FIFO at the edge.
  - The word appears on out_X_data with out_X_valid=1 in the next cycle when that FIFO was empty (latency 1 cycle).
- Pop: when out_X_valid & out_X_ready, the head advances at the edge.
  - out_X_ready while empty is ignored.
- Push and pop on the same FIFO in the same cycle (non-empty, not full): count is unchanged and order is preserved.
- Push to one FIFO while popping the other: both happen independently.
- Ordering: strict FIFO order per destination. Read and write pointers wrap modulo DEPTH.
- Full: count=DEPTH, so in_ready=0 for words to that destination. A blocked word is not redirected to the other FIFO; the source holds it.
- Ping-pong pointer:
  - toggles only on an accepted transfer while mode_alt=1;
  - holds its value while mode_alt=0;
  - switching mode_alt back to 1 resumes from the held value.
- mode_alt or in_select changing while in_valid=1 and in_ready=0 is legal; dest and in_ready re-evaluate combinationally.
- out_X_data is registered FIFO storage (head entry) and is stable while out_X_valid=1 and no pop occurs.

Decomposition:
- Shared constants file holds:
  - DATA_W=10;
  - destination encodings DEST_A=0, DEST_B=1.
- Sub-module demux_fifo:
  - single-channel synchronous FIFO with push/pop/full/empty/count and clk/rst;
  - instantiated twice (A, B).
- Top level contains only:
  - dest selection;
  - in_ready generation;
  - push gating;
  - the ping-pong pointer register.

Test Plan:
- Reset then idle: all outputs 0, in_ready=1 for either select.
- mode_alt=0, select=0, push 0x2A5 -> out_a_valid=1 with out_a_data=0x2A5 next cycle; out_b_valid stays 0.
- mode_alt=0, select=1, out_b_ready=0, push 0x001, 0x3FF, 0x155:
  - b_count reaches 2 and in_ready=0 on the third word;
  - raise out_b_ready -> pops 0x001 then 0x3FF in order;
  - 0x155 is accepted once count<2.
- mode_alt=1, push 0x010, 0x020, 0x030, 0x040 back-to-back, both readies=1 -> A gets 0x010, 0x030 and B gets 0x020, 0x040.
- mode_alt=1, in_valid=0 for 3 cycles between words -> pointer does not advance; the next word goes to the expected side.
- A holding 1 word; push A and pop A in the same cycle -> a_count stays 1 and the new head is the pushed word.
- Assert rst for one cycle with both FIFOs full -> next cycle counts=0, valids=0, ping-pong restarts at A.
